// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding imem request and a 2-entry {pc, instr} queue toward decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (flag and stall on misaligned redirect targets).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign
);

  logic [31:0] pc_r, pc_s;
  logic [31:0] hd_pc_r, hd_pc_s, hd_instr_r, hd_instr_s;
  logic [31:0] tl_pc_r, tl_pc_s, tl_instr_r, tl_instr_s;
  logic [1:0]  count_r, count_s;
  logic        misalign_r, misalign_s;
  logic        enq_s, deq_s;
  logic        redirect_bad_s;
  logic [31:0] redirect_tgt_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_bad_s = (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt_s = redirect_pc;
`else
  assign redirect_bad_s = 1'b0;
  assign redirect_tgt_s = {redirect_pc[31:2], 2'b00};
`endif

  // The request is held purely by state, so it cannot change until ack, redirect or reset.
  assign imem_req  = !rst && (count_r != 2'd2) && !misalign_r;
  assign imem_addr = pc_r;
  assign if_valid  = (count_r != 2'd0);
  assign if_instr  = hd_instr_r;
  assign if_pc     = hd_pc_r;
  assign misalign  = misalign_r;

  // Next-state: redirect flushes everything; otherwise dequeue shifts the tail up before enqueue writes.
  always_comb begin
    pc_s       = pc_r;
    hd_pc_s    = hd_pc_r;
    hd_instr_s = hd_instr_r;
    tl_pc_s    = tl_pc_r;
    tl_instr_s = tl_instr_r;
    count_s    = count_r;
    misalign_s = misalign_r;
    enq_s      = imem_req && imem_ack;
    deq_s      = (count_r != 2'd0) && id_ready;
    if (redirect) begin
      count_s    = 2'd0;
      pc_s       = redirect_tgt_s;
      misalign_s = redirect_bad_s;
    end else begin
      if (deq_s) begin
        hd_pc_s    = tl_pc_r;
        hd_instr_s = tl_instr_r;
        count_s    = count_r - 2'd1;
      end else begin
        count_s = count_r;
      end
      if (enq_s) begin
        pc_s = pc_r + 32'd4;
        case (count_s)
          2'd0: begin
            hd_pc_s    = pc_r;
            hd_instr_s = imem_rdata;
          end
          2'd1: begin
            tl_pc_s    = pc_r;
            tl_instr_s = imem_rdata;
          end
          default: begin
            tl_pc_s    = tl_pc_r;
            tl_instr_s = tl_instr_r;
          end
        endcase
        count_s = count_s + 2'd1;
      end else begin
        pc_s = pc_r;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      hd_pc_r    <= 32'h0000_0000;
      hd_instr_r <= 32'h0000_0000;
      tl_pc_r    <= 32'h0000_0000;
      tl_instr_r <= 32'h0000_0000;
      count_r    <= 2'd0;
      misalign_r <= 1'b0;
    end else begin
      pc_r       <= pc_s;
      hd_pc_r    <= hd_pc_s;
      hd_instr_r <= hd_instr_s;
      tl_pc_r    <= tl_pc_s;
      tl_instr_r <= tl_instr_s;
      count_r    <= count_s;
      misalign_r <= misalign_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based fetch model predicts requests and the instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign;

  fetch_unit #(.RESET_PC(RESET_PC_TB)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Model: expected FIFO contents {pc, instr}, expected fetch PC and misalign flag
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_mis;
  logic        mon_en = 1'b0;
  int          errs = 0;
  int          checks = 0;
  int          pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the model mid-cycle and consumes accepted instructions
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_req;
      exp_req = !rst && (exp_q.size() < 2) && !m_mis;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("misalign", 32'(misalign), 32'(m_mis));
      chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      if (if_valid && exp_q.size() != 0) begin
        chk("if_pc", if_pc, exp_q[0][63:32]);
        chk("if_instr", if_instr, exp_q[0][31:0]);
        if (id_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic step(input logic a, input logic [31:0] d, input logic r,
                      input logic rd, input logic [31:0] rp, input logic rs);
    logic req_now;
    imem_ack = a; imem_rdata = d; id_ready = r;
    redirect = rd; redirect_pc = rp; rst = rs;
    req_now = !rs && (exp_q.size() < 2) && !m_mis;
    @(posedge clk); #1;
    if (rs) begin
      exp_q.delete();
      m_pc  = RESET_PC_TB;
      m_mis = 1'b0;
    end else if (rd) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      m_pc  = rp;
      m_mis = (rp[1:0] != 2'b00);
`else
      m_pc  = rp & 32'hFFFF_FFFC;
      m_mis = 1'b0;
`endif
    end else if (req_now && a) begin
      exp_q.push_back({m_pc, d});
      m_pc = m_pc + 32'd4;
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); m_pc = RESET_PC_TB; m_mis = 1'b0;
    mon_en = 1'b1;
    chk("reset_if_pc", if_pc, 32'h0);
    chk("reset_if_instr", if_instr, 32'h0);

    // Streaming fetch: ack every cycle, decode always ready
    step(1'b1, NOP, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    // Back-pressure fills the queue, then drains in order
    for (int i = 0; i < 5; i++) step(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB000_0000 + i, 1'b1, 1'b0, 32'h0, 1'b0);
    // Redirect while full with a concurrent ack
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    // Address wrap
    step(1'b0, NOP, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hE000_0000 + i, 1'b1, 1'b0, 32'h0, 1'b0);
    // Reset mid-request with delayed ack
    step(1'b0, NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, NOP, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, NOP, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    // Misaligned redirect target, then aligned recovery
    step(1'b1, NOP, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, NOP, 1'b1, 1'b1, 32'h0000_0104, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, NOP, 1'b1, 1'b0, 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      if ($urandom_range(3) != 0) rp[1:0] = 2'b00;
`endif
      step($urandom_range(2) != 0, $urandom, $urandom_range(1) != 0,
           $urandom_range(19) == 0, rp, $urandom_range(199) == 0);
    end
    step(1'b0, NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    mon_en = 1'b0;
    chk("instructions_consumed", 32'(pops > 200), 32'h1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
